// File: rtl/param_updown_counter.sv
// Parameterised modulo up/down counter with optional saturation.
// Counts in 0..MODULUS-1. tc is combinational so that a following stage's
// en can be tied straight to it; out, ovf and sat are registered.
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             sat
);

  // Reject parameter sets that cannot describe a valid counter.
  generate
    if ((WIDTH < 1) || (MODULUS < 2) || (SATURATE < 0) || (SATURATE > 1) ||
        ((WIDTH < 31) && (MODULUS > (1 << WIDTH)))) begin : g_bad_params
      $error("param_updown_counter: illegal WIDTH/MODULUS/SATURATE combination");
    end
  endgenerate

  // The count is kept one bit wider than out so that increment, decrement
  // and the load clamp never alias a value >= MODULUS back into range.
  localparam logic [WIDTH:0] MAX_VAL      = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE          = (WIDTH+1)'(1);
  localparam bit             HOLD_AT_ENDS = (SATURATE == 1);

  logic [WIDTH:0] cnt_reg;
  logic [WIDTH:0] cnt_next;
  logic [WIDTH:0] load_ext;
  logic           ovf_reg;
  logic           ovf_next;
  logic           sat_reg;
  logic           sat_next;
  logic           at_top;
  logic           at_bottom;

  assign load_ext  = {1'b0, load_val};
  assign at_top    = (cnt_reg == MAX_VAL);
  assign at_bottom = (cnt_reg == '0);

  // Terminal count looks only at en/up/count so cascaded stages see no clear/load path.
  assign tc = en & ((up & at_top) | (~up & at_bottom));

  // Next-state selection: clear beats load beats count; idle holds count and sat.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = 1'b0;
    sat_next = sat_reg;
    if (clear) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (load) begin
      cnt_next = (load_ext > MAX_VAL) ? MAX_VAL : load_ext;
      sat_next = 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          cnt_next = cnt_reg + ONE;
          sat_next = 1'b0;
        end else if (HOLD_AT_ENDS) begin
          sat_next = 1'b1;
        end else begin
          cnt_next = '0;
          ovf_next = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          cnt_next = cnt_reg - ONE;
          sat_next = 1'b0;
        end else if (HOLD_AT_ENDS) begin
          sat_next = 1'b1;
        end else begin
          cnt_next = MAX_VAL;
          ovf_next = 1'b1;
        end
      end
    end
  end

  // State registers; rst overrides everything, including a pending ovf pulse.
  always_ff @(posedge Clk) begin
    if (rst) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      sat_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      sat_reg <= sat_next;
    end
  end

  assign out = cnt_reg[WIDTH-1:0];
  assign ovf = ovf_reg;
  assign sat = sat_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: a decade wrap counter (A),
// a saturating hex counter (B) and a two-stage decade cascade (C).
module tb_param_updown_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instance A: WIDTH=4, MODULUS=10, SATURATE=0
  logic       a_rst, a_clear, a_load, a_en, a_up;
  logic [3:0] a_lv, a_out;
  logic       a_tc, a_ovf, a_sat;
  // Instance B: WIDTH=4, MODULUS=16, SATURATE=1
  logic       b_rst, b_clear, b_load, b_en, b_up;
  logic [3:0] b_lv, b_out;
  logic       b_tc, b_ovf, b_sat;
  // Cascade C: low stage drives high stage en via tc
  logic       c_rst, c_clear, c_load, c_en, c_up;
  logic [3:0] c_lv, cl_out, ch_out;
  logic       cl_tc, cl_ovf, cl_sat, ch_tc, ch_ovf, ch_sat;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
    .Clk(Clk), .rst(a_rst), .clear(a_clear), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .out(a_out), .tc(a_tc), .ovf(a_ovf), .sat(a_sat));

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_b (
    .Clk(Clk), .rst(b_rst), .clear(b_clear), .load(b_load), .load_val(b_lv),
    .en(b_en), .up(b_up), .out(b_out), .tc(b_tc), .ovf(b_ovf), .sat(b_sat));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .Clk(Clk), .rst(c_rst), .clear(c_clear), .load(c_load), .load_val(c_lv),
    .en(c_en), .up(c_up), .out(cl_out), .tc(cl_tc), .ovf(cl_ovf), .sat(cl_sat));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .Clk(Clk), .rst(c_rst), .clear(c_clear), .load(c_load), .load_val(c_lv),
    .en(cl_tc), .up(c_up), .out(ch_out), .tc(ch_tc), .ovf(ch_ovf), .sat(ch_sat));

  // tc is checked against the inputs of the step (before the edge);
  // out/ovf/sat are checked after that edge. For the cascade, out is
  // hi*10+lo and tc/ovf/sat are packed as {hi, lo}.
  typedef struct {
    int tgt;
    int etc;
    int eout;
    int eovf;
    int esat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string what, input int tgt, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s tgt=%0d got %0d want %0d", what, tgt, got, want);
    end
  endtask

  function automatic int act_out(input int tgt);
    case (tgt)
      0:       return int'(a_out);
      1:       return int'(b_out);
      default: return int'(ch_out) * 10 + int'(cl_out);
    endcase
  endfunction

  function automatic int act_tc(input int tgt);
    case (tgt)
      0:       return int'(a_tc);
      1:       return int'(b_tc);
      default: return int'({ch_tc, cl_tc});
    endcase
  endfunction

  function automatic int act_ovf(input int tgt);
    case (tgt)
      0:       return int'(a_ovf);
      1:       return int'(b_ovf);
      default: return int'({ch_ovf, cl_ovf});
    endcase
  endfunction

  function automatic int act_sat(input int tgt);
    case (tgt)
      0:       return int'(a_sat);
      1:       return int'(b_sat);
      default: return int'({ch_sat, cl_sat});
    endcase
  endfunction

  // Drive one cycle of inputs for a target (others idle) and queue the expectation.
  task automatic step(input int tgt, input int rst, input int clr, input int ld,
                      input int lv, input int en, input int up,
                      input int eout, input int eovf, input int esat, input int etc);
    exp_t e;
    @(posedge Clk);
    #1;
    a_rst = 1'b0; a_clear = 1'b0; a_load = 1'b0; a_en = 1'b0;
    b_rst = 1'b0; b_clear = 1'b0; b_load = 1'b0; b_en = 1'b0;
    c_rst = 1'b0; c_clear = 1'b0; c_load = 1'b0; c_en = 1'b0;
    case (tgt)
      0: begin
        a_rst = (rst != 0); a_clear = (clr != 0); a_load = (ld != 0);
        a_lv = 4'(lv); a_en = (en != 0); a_up = (up != 0);
      end
      1: begin
        b_rst = (rst != 0); b_clear = (clr != 0); b_load = (ld != 0);
        b_lv = 4'(lv); b_en = (en != 0); b_up = (up != 0);
      end
      default: begin
        c_rst = (rst != 0); c_clear = (clr != 0); c_load = (ld != 0);
        c_lv = 4'(lv); c_en = (en != 0); c_up = (up != 0);
      end
    endcase
    e.tgt = tgt; e.etc = etc; e.eout = eout; e.eovf = eovf; e.esat = esat;
    sb_q.push_back(e);
  endtask

  // Monitor: on each falling edge, finish the previous entry's registered checks,
  // then pop the next entry and check its combinational tc.
  initial begin
    exp_t cur;
    bit   pend;
    pend = 1'b0;
    forever begin
      @(negedge Clk);
      if (pend) begin
        chk("out", cur.tgt, act_out(cur.tgt), cur.eout);
        chk("ovf", cur.tgt, act_ovf(cur.tgt), cur.eovf);
        chk("sat", cur.tgt, act_sat(cur.tgt), cur.esat);
        $display("txn tgt=%0d out=%0d ovf=%0d sat=%0d (want %0d/%0d/%0d)",
                 cur.tgt, act_out(cur.tgt), act_ovf(cur.tgt), act_sat(cur.tgt),
                 cur.eout, cur.eovf, cur.esat);
      end
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        chk("tc", cur.tgt, act_tc(cur.tgt), cur.etc);
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1; a_clear = 1'b0; a_load = 1'b0; a_lv = 4'd0; a_en = 1'b0; a_up = 1'b1;
    b_rst = 1'b1; b_clear = 1'b0; b_load = 1'b0; b_lv = 4'd0; b_en = 1'b0; b_up = 1'b1;
    c_rst = 1'b1; c_clear = 1'b0; c_load = 1'b0; c_lv = 4'd0; c_en = 1'b0; c_up = 1'b1;
    repeat (2) @(posedge Clk);

    // ---- A: decade wrap counter ----
    //   tgt rst clr ld lv en up  out ovf sat tc
    step(0, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0);   // held in reset even with en
    for (int k = 1; k <= 10; k++)
      step(0, 0, 0, 0, 0, 1, 1, k % 10, (k == 10) ? 1 : 0, 0, (k == 10) ? 1 : 0);
    step(0, 0, 0, 0, 0, 1, 0,   9, 1, 0, 1);   // 0 -> 9 down wrap
    for (int k = 8; k >= 0; k--)
      step(0, 0, 0, 0, 0, 1, 0, k, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,   9, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 1);   // direction flip at 9
    step(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0);   // en=0 holds
    step(0, 0, 0, 1, 13, 1, 1,  9, 0, 0, 0);   // clamp, load beats en
    step(0, 0, 1, 1, 5, 1, 1,   0, 0, 0, 1);   // clear beats load; tc ignores them
    step(0, 0, 0, 1, 10, 0, 1,  9, 0, 0, 0);   // load_val == MODULUS clamps
    step(0, 1, 0, 0, 0, 1, 1,   0, 0, 0, 1);   // rst on the would-be wrap edge
    step(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0);   // resume
    step(0, 0, 0, 1, 9, 0, 1,   9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 1);   // wrap, ovf pulse
    step(0, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0);   // rst during pulse
    step(0, 0, 0, 1, 4, 0, 0,   4, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0,   0, 0, 0, 0);   // clear beats count

    // ---- B: saturating counter ----
    step(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    step(1, 0, 0, 1, 15, 0, 1, 15, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step(1, 0, 0, 0, 0, 1, 1, 15, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 0,  14, 0, 0, 0);   // moving away clears sat
    step(1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1);   // hold at bottom
    step(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);   // sat sticky while idle
    step(1, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0);   // clear drops sat
    step(1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1);
    step(1, 0, 0, 1, 3, 1, 0,   3, 0, 0, 1);   // load drops sat, count not applied

    // ---- C: two-digit decade cascade ----
    step(2, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    for (int k = 1; k <= 100; k++) begin
      int lo_pre, hi_pre, etc, eovf;
      lo_pre = (k - 1) % 10;
      hi_pre = ((k - 1) / 10) % 10;
      etc  = ((lo_pre == 9) ? 1 : 0) + ((lo_pre == 9 && hi_pre == 9) ? 2 : 0);
      eovf = ((k % 10 == 0) ? 1 : 0) + ((k == 100) ? 2 : 0);
      step(2, 0, 0, 0, 0, 1, 1, k % 100, eovf, 0, etc);
    end

    // Drain the scoreboard within a bounded number of cycles.
    @(posedge Clk);
    #1;
    c_en = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge Clk);
    repeat (2) @(negedge Clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain queue=%0d want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16: count range is 0..MODULUS-1.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-004 Port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port clear, input, 1: synchronous soft clear to 0.
REQ-007 Port load, input, 1: synchronous parallel load.
REQ-008 Port load_val, input, WIDTH: value to load.
REQ-009 Port en, input, 1: count enable.
REQ-010 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-011 Port out, output, WIDTH: current count, registered.
REQ-012 Port tc, output, 1: terminal count, combinational, for cascading.
REQ-013 Port ovf, output, 1: registered one-cycle wrap pulse.
REQ-014 Port sat, output, 1: registered saturation flag.

Function
REQ-015 Elaboration SHALL fail if WIDTH < 1, MODULUS < 2, MODULUS > 2**WIDTH, or SATURATE is not 0 or 1.
REQ-016 Per-edge priority SHALL be: rst > clear > load > en; with no control active, out holds.
REQ-017 clear=1 SHALL set out=0, ovf=0 and sat=0.
REQ-018 load=1 SHALL set out=load_val; if load_val >= MODULUS, out SHALL be MODULUS-1. ovf=0; sat=0.
REQ-019 en=1, up=1, out < MODULUS-1: out SHALL become out+1.
REQ-020 en=1, up=0, out > 0: out SHALL become out-1.
REQ-021 en=1, up=1, out = MODULUS-1:
  - SATURATE=0: out SHALL become 0 and ovf SHALL be 1 for exactly the next cycle.
  - SATURATE=1: out SHALL hold and sat SHALL become 1.
REQ-022 en=1, up=0, out = 0:
  - SATURATE=0: out SHALL become MODULUS-1 and ovf SHALL be 1 for exactly the next cycle.
  - SATURATE=1: out SHALL hold and sat SHALL become 1.
REQ-023 ovf SHALL be 0 on every edge that does not perform a wrap.
REQ-024 ovf SHALL never be 1 when SATURATE=1.
REQ-025 sat SHALL stay 1 until rst, clear, load, or an enabled count moving away from the boundary; that count SHALL clear sat on the same edge.
REQ-026 tc SHALL be 1 iff en=1 and either (up=1 and out=MODULUS-1) or (up=0 and out=0).
REQ-027 tc SHALL carry no dependency on clear or load, so that a chained stage's en can be driven directly by tc.
REQ-028 Latency from any control input to out, ovf or sat SHALL be one Clk edge.
REQ-029 Arithmetic SHALL be performed in WIDTH+1 bits, so that out never holds a value >= MODULUS.
REQ-030 A change of up while en=1 SHALL take effect on the next edge, with no lost or extra count.
REQ-031 If load and en are both 1, load SHALL win and the count SHALL NOT also be applied.
REQ-032 If clear and load are both 1, clear SHALL win.

Reset
REQ-033 rst=1 at a Clk edge SHALL force out=0, ovf=0 and sat=0, regardless of all other inputs.
REQ-034 Assertion of rst mid-count or mid-ovf-pulse SHALL cancel the pulse on that edge.
REQ-035 Outputs SHALL hold reset values while rst=1; counting SHALL resume on the first edge with rst=0 and en=1.
REQ-036 No asynchronous path from rst to any output SHALL exist.

Verification
REQ-037 Decade wrap: WIDTH=4, MODULUS=10, SATURATE=0, up=1, en=1 from reset
  -> out = 0,1..9,0; ovf=1 only in the cycle out returns to 0; tc=1 while out=9.
REQ-038 Down wrap: same parameters, up=0 from out=0
  -> out = 9,8..0,9; ovf pulses on the 0->9 transition.
REQ-039 Saturation: SATURATE=1, load 15 with MODULUS=16, then up=1 for 3 cycles
  -> out stays 15 and sat=1; then up=0 for one cycle -> out=14 and sat=0.
REQ-040 Load clamp and priority: MODULUS=10, load_val=13 with load=1 and en=1
  -> out=9.
  Then clear=1 with load=1 -> out=0.
REQ-041 Reset mid-operation: assert rst on the edge where out would wrap 9->0
  -> out=0, ovf=0, sat=0.
  Then release with en=1 -> out=1 on the next edge.
REQ-042 Cascade: two instances (WIDTH=4, MODULUS=10), with the high stage's en driven by the low stage's tc, run for 100 edges
  -> combined count 00..99 and back to 00; the high stage's ovf pulses once.
